hazard_stall_controller: RTL and testbench

// - Pipeline sequencer for the 5-stage core. Decides stall, bubble and flush for IF/ID/EX.
// - Covers load-use and branch-operand hazards that forwarding cannot resolve.
// - Owns the multi-cycle MULT/DIV unit (MDU): issues start, counts its latency, raises the HI/LO write strobe.
// - Sits beside the forwarding unit and drives the hold/clear controls of the PipelineReg stages.

---
 rtl/hazard_stall_controller_pkg.sv | 24 ++
 rtl/hazard_stall_controller_mdu.sv | 77 +++++++
 rtl/hazard_stall_controller.sv | 79 +++++++
 tb/tb_hazard_stall_controller.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_controller_pkg.sv
// Shared types and helpers for the pipeline hazard/stall controller.
// Holds the MDU sequencer state encoding and the register-match helper.
package hazard_stall_controller_pkg;

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_RUN  = 2'd1,
        M_DONE = 2'd2
    } mdu_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // True when the ID instruction actually reads register r; $0 is hardwired, never a hazard.
    function automatic logic reg_match(
        input logic [4:0] r,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       use_rs,
        input logic       use_rt
    );
        return (r != REG_ZERO) && ((use_rs && (r == rs)) || (use_rt && (r == rt)));
    endfunction

endpackage

// File: rtl/hazard_stall_controller_mdu.sv
// MULT/DIV sequencer: issues the start pulse, counts the operation latency
// and raises the one-cycle HI/LO write strobe on completion.
module mdu_sequencer
    import hazard_stall_controller_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic issue_req,
    input  logic issue_div,
    output logic mdu_start,
    output logic mdu_busy,
    output logic hilo_we
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    mdu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= M_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mdu_start = 1'b0;
        hilo_we   = 1'b0;
        case (state_q)
            M_IDLE: begin
                if (issue_req) begin
                    mdu_start = 1'b1;
                    state_d   = M_RUN;
                    cnt_d     = issue_div ? DIV_LOAD : MULT_LOAD;
                end
            end
            M_RUN: begin
                // Leaving RUN on count 1 lands DONE exactly N cycles after the start pulse.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = M_DONE;
                end
            end
            M_DONE: begin
                hilo_we = 1'b1;
                if (issue_req) begin
                    mdu_start = 1'b1;
                    state_d   = M_RUN;
                    cnt_d     = issue_div ? DIV_LOAD : MULT_LOAD;
                end else begin
                    state_d = M_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = M_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign mdu_busy = (state_q != M_IDLE);

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencer for the 5-stage core: load-use, branch-operand and MDU
// structural hazards drive stall/bubble/flush of IF/ID/EX.
module hazard_stall_controller
    import hazard_stall_controller_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_is_branch,
    input  logic       id_branch_taken,
    input  logic       id_is_mdu,
    input  logic       id_mdu_is_div,
    input  logic       id_reads_hilo,
    input  logic [4:0] ex_rd,
    input  logic       ex_reg_write,
    input  logic       ex_mem_read,
    input  logic [4:0] mem_rd,
    input  logic       mem_mem_read,
    output logic       stall_if,
    output logic       stall_id,
    output logic       bubble_ex,
    output logic       flush_id,
    output logic       mdu_start,
    output logic       mdu_busy,
    output logic       hilo_we
);

    if (MULT_CYCLES < 1 || MULT_CYCLES > (1 << CNT_W)) begin : g_bad_mult
        $error("MULT_CYCLES out of range for CNT_W");
    end
    if (DIV_CYCLES < 1 || DIV_CYCLES > (1 << CNT_W)) begin : g_bad_div
        $error("DIV_CYCLES out of range for CNT_W");
    end

    logic ex_match, mem_match;
    logic load_use, br_haz, mdu_haz;
    logic stall_raw, stall;
    logic issue_req;

    always_comb begin
        ex_match  = reg_match(ex_rd, id_rs, id_rt, id_use_rs, id_use_rt);
        mem_match = reg_match(mem_rd, id_rs, id_rt, id_use_rs, id_use_rt);
        load_use  = ex_mem_read && ex_match;
        br_haz    = id_is_branch && ((ex_reg_write && ex_match) || (mem_mem_read && mem_match));
        // Busy covers DONE too, so MFHI/MFLO waits until HI/LO is actually written.
        mdu_haz   = (id_is_mdu || id_reads_hilo) && mdu_busy;
        stall_raw = load_use || br_haz || mdu_haz;
    end

    // Reset forces every output low immediately, not just at the next edge.
    assign stall     = !rst && stall_raw;
    assign stall_if  = stall;
    assign stall_id  = stall;
    assign bubble_ex = stall;
    assign flush_id  = !rst && id_branch_taken && !stall_raw;
    assign issue_req = !rst && id_is_mdu && !stall_raw;

    mdu_sequencer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_mdu (
        .clk       (clk),
        .rst       (rst),
        .issue_req (issue_req),
        .issue_div (id_mdu_is_div),
        .mdu_start (mdu_start),
        .mdu_busy  (mdu_busy),
        .hilo_we   (hilo_we)
    );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a timeline model.
module tb_hazard_stall_controller;

    localparam int MULT_N = 4;
    localparam int DIV_N  = 32;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       br;
        logic       taken;
        logic       mdu;
        logic       div;
        logic       hilo;
        logic [4:0] exrd;
        logic       exw;
        logic       exld;
        logic [4:0] memrd;
        logic       memld;
    } in_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
    logic       id_use_rs, id_use_rt, id_is_branch, id_branch_taken;
    logic       id_is_mdu, id_mdu_is_div, id_reads_hilo;
    logic       ex_reg_write, ex_mem_read, mem_mem_read;
    logic       stall_if, stall_id, bubble_ex, flush_id, mdu_start, mdu_busy, hilo_we;

    always #5 clk = ~clk;

    hazard_stall_controller #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N),
        .CNT_W       (6)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_use_rs       (id_use_rs),
        .id_use_rt       (id_use_rt),
        .id_is_branch    (id_is_branch),
        .id_branch_taken (id_branch_taken),
        .id_is_mdu       (id_is_mdu),
        .id_mdu_is_div   (id_mdu_is_div),
        .id_reads_hilo   (id_reads_hilo),
        .ex_rd           (ex_rd),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .mem_rd          (mem_rd),
        .mem_mem_read    (mem_mem_read),
        .stall_if        (stall_if),
        .stall_id        (stall_id),
        .bubble_ex       (bubble_ex),
        .flush_id        (flush_id),
        .mdu_start       (mdu_start),
        .mdu_busy        (mdu_busy),
        .hilo_we         (hilo_we)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: the single in-flight MDU op is described by its start cycle and length.
    bit have_op = 1'b0;
    int op_t0   = 0;
    int op_n    = 0;

    int   last_start = -1;
    int   last_hilo  = -1;
    logic last_stall = 1'b0;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0b expected=%0b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic in_t nop();
        in_t v;
        v = '0;
        return v;
    endfunction

    function automatic bit reads(input in_t v, input logic [4:0] r);
        return (r != 5'd0) && ((v.use_rs && r == v.rs) || (v.use_rt && r == v.rt));
    endfunction

    task automatic apply(input in_t v);
        id_rs           = v.rs;
        id_rt           = v.rt;
        id_use_rs       = v.use_rs;
        id_use_rt       = v.use_rt;
        id_is_branch    = v.br;
        id_branch_taken = v.taken;
        id_is_mdu       = v.mdu;
        id_mdu_is_div   = v.div;
        id_reads_hilo   = v.hilo;
        ex_rd           = v.exrd;
        ex_reg_write    = v.exw;
        ex_mem_read     = v.exld;
        mem_rd          = v.memrd;
        mem_mem_read    = v.memld;
    endtask

    // One pipeline cycle: drive inputs, check all outputs against the model, advance the model.
    task automatic step(input in_t v);
        bit lu, bh, busy, hw, st, fl, start;
        @(negedge clk);
        cyc++;
        apply(v);
        #2;
        lu    = v.exld && reads(v, v.exrd);
        bh    = v.br && ((v.exw && reads(v, v.exrd)) || (v.memld && reads(v, v.memrd)));
        busy  = have_op && (cyc > op_t0) && (cyc <= op_t0 + op_n);
        hw    = have_op && (cyc == op_t0 + op_n);
        st    = lu || bh || ((v.mdu || v.hilo) && busy);
        fl    = v.taken && !st;
        start = v.mdu && !st && !busy;
        if (rst) begin
            st = 0; fl = 0; start = 0; busy = 0; hw = 0;
        end
        chk("stall_if", stall_if, st);
        chk("stall_id", stall_id, st);
        chk("bubble_ex", bubble_ex, st);
        chk("flush_id", flush_id, fl);
        chk("mdu_start", mdu_start, start);
        chk("mdu_busy", mdu_busy, busy);
        chk("hilo_we", hilo_we, hw);
        $display("cyc=%0d stall=%0b flush=%0b start=%0b busy=%0b hilo_we=%0b",
                 cyc, stall_if, flush_id, mdu_start, mdu_busy, hilo_we);
        last_stall = stall_if;
        if (mdu_start) last_start = cyc;
        if (hilo_we)   last_hilo  = cyc;
        if (start) begin
            have_op = 1'b1;
            op_t0   = cyc;
            op_n    = v.div ? DIV_N : MULT_N;
        end
        if (rst) have_op = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_t v;
        int  t, t2, prev_hilo;

        // Reset with a live load-use hazard and a taken branch: everything must read 0.
        v = nop();
        v.exrd = 5'd2; v.exld = 1; v.exw = 1; v.rs = 5'd2; v.use_rs = 1; v.taken = 1; v.mdu = 1;
        rst = 1'b1;
        apply(v);
        #1;
        chk("rst_stall", stall_if, 1'b0);
        chk("rst_flush", flush_id, 1'b0);
        chk("rst_start", mdu_start, 1'b0);
        step(v);
        step(v);
        @(negedge clk);
        rst = 1'b0;

        // LW $2 in EX, ADD reading $2 in ID: one stall, then clear with the load in MEM.
        v = nop();
        v.exrd = 5'd2; v.exld = 1; v.exw = 1; v.rs = 5'd2; v.use_rs = 1;
        step(v);
        chk("lu_stall_lit", stall_if, 1'b1);
        v = nop();
        v.memrd = 5'd2; v.memld = 1; v.rs = 5'd2; v.use_rs = 1;
        step(v);
        chk("lu_release_lit", stall_if, 1'b0);

        // LW $3 then BEQ $3,$0 (taken): two stalls, then a single flush.
        v = nop();
        v.exrd = 5'd3; v.exld = 1; v.exw = 1;
        v.br = 1; v.taken = 1; v.rs = 5'd3; v.rt = 5'd0; v.use_rs = 1; v.use_rt = 1;
        step(v);
        chk("br_ld_stall1_lit", stall_if, 1'b1);
        chk("br_ld_noflush1_lit", flush_id, 1'b0);
        v.exrd = 5'd0; v.exld = 0; v.exw = 0; v.memrd = 5'd3; v.memld = 1;
        step(v);
        chk("br_ld_stall2_lit", stall_if, 1'b1);
        v.memrd = 5'd0; v.memld = 0;
        step(v);
        chk("br_ld_flush_lit", flush_id, 1'b1);
        chk("br_ld_release_lit", stall_if, 1'b0);

        // ADD $4 in EX, BNE $4 taken: one stall with flush held, then flush.
        v = nop();
        v.exrd = 5'd4; v.exw = 1; v.br = 1; v.taken = 1; v.rs = 5'd4; v.use_rs = 1;
        step(v);
        chk("br_alu_stall_lit", stall_if, 1'b1);
        chk("br_alu_noflush_lit", flush_id, 1'b0);
        v.exrd = 5'd0; v.exw = 0;
        step(v);
        chk("br_alu_flush_lit", flush_id, 1'b1);

        // DIV at t, MFLO in ID from t+1: hilo_we at t+32, MFLO leaves at t+33.
        step(nop());
        v = nop(); v.mdu = 1; v.div = 1;
        step(v);
        t = cyc;
        chk_int("div_start_lit", last_start, t);
        v = nop(); v.hilo = 1;
        for (int k = 0; k < 60; k++) begin
            step(v);
            if (!last_stall) break;
        end
        chk_int("div_hilo_lat", last_hilo - t, 32);
        chk_int("mflo_leave", cyc - t, 33);

        // MULT at t, second MULT waits in ID: starts t+5, completes t+9.
        v = nop(); v.mdu = 1;
        step(v);
        t = cyc;
        chk_int("mult_start_lit", last_start, t);
        for (int k = 0; k < 20; k++) begin
            step(v);
            if (last_start != t) break;
        end
        t2 = last_start;
        chk_int("mult2_start", t2 - t, 5);
        for (int k = 0; k < 6; k++) step(nop());
        chk_int("mult2_hilo", last_hilo - t, 9);

        // DIV then asynchronous reset at t+10: outputs drop at once, no hilo_we later.
        v = nop(); v.mdu = 1; v.div = 1;
        step(v);
        t = cyc;
        for (int k = 0; k < 9; k++) step(nop());
        v = nop(); v.hilo = 1; v.taken = 1;
        step(v);
        chk("pre_rst_busy_lit", mdu_busy, 1'b1);
        chk_int("pre_rst_cycle", cyc - t, 10);
        prev_hilo = last_hilo;
        rst = 1'b1;
        have_op = 1'b0;
        #1;
        chk("midrst_busy", mdu_busy, 1'b0);
        chk("midrst_stall", stall_if, 1'b0);
        chk("midrst_flush", flush_id, 1'b0);
        step(v);
        rst = 1'b0;
        for (int k = 0; k < 40; k++) step(nop());
        chk_int("no_hilo_after_rst", last_hilo, prev_hilo);

        // $0 never matches.
        v = nop();
        v.exrd = 5'd0; v.exld = 1; v.exw = 1; v.memld = 1; v.br = 1;
        v.rs = 5'd0; v.rt = 5'd0; v.use_rs = 1; v.use_rt = 1;
        step(v);
        chk("zero_reg_lit", stall_if, 1'b0);

        // Randomized traffic on a small register set to provoke frequent hazards.
        for (int k = 0; k < 1500; k++) begin
            v = nop();
            v.rs     = 5'($urandom_range(0, 3));
            v.rt     = 5'($urandom_range(0, 3));
            v.use_rs = 1'($urandom_range(0, 1));
            v.use_rt = 1'($urandom_range(0, 1));
            v.br     = ($urandom_range(0, 3) == 0);
            v.taken  = v.br && ($urandom_range(0, 1) == 1);
            v.mdu    = ($urandom_range(0, 7) == 0);
            v.div    = v.mdu && ($urandom_range(0, 3) == 0);
            v.hilo   = !v.mdu && ($urandom_range(0, 5) == 0);
            v.exrd   = 5'($urandom_range(0, 3));
            v.exw    = 1'($urandom_range(0, 1));
            v.exld   = v.exw && ($urandom_range(0, 2) == 0);
            v.memrd  = 5'($urandom_range(0, 3));
            v.memld  = ($urandom_range(0, 2) == 0);
            step(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
